alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the datapath ALU. Executes one operation per transaction on two WIDTH-bit operands and returns a registered result with registered Z/N/V status flags. Single-cycle ops complete in one clock. MUL is an iterative shift-add multiplier taking WIDTH clocks. Sits between the register-file read stage and writeback, with valid/ready on both sides so the controller FSM can stall either end.

## Interface
- WIDTH, 16, operand/result width in bits (≥ 4)
- CNT_W, $clog2(WIDTH+1), width of the MUL iteration counter
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept; high only in IDLE
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 NOTB, 100 OR, 101 XOR, 110 MUL, 111 PASSA
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- flush  in  1  synchronous abort; returns to IDLE and discards any in-flight or held result
- out_valid  out  1  result and flags valid; held until accepted
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- z, n, v  out  1 each  zero, negative (result MSB), overflow
- busy  out  1  high in MUL state

## Operation
- States: IDLE, MUL, DONE. Reset enters IDLE.
- IDLE: in_ready=1. An accept (in_valid & in_ready) latches op, a and b.
  - MUL goes to MUL.
  - Every other op computes combinationally from the latched inputs, registers result/flags, and goes to DONE.
- MUL: unsigned shift-add over a 2·WIDTH accumulator, one multiplier bit per clock, counter from 0 to WIDTH-1.
  - On the edge that processes bit WIDTH-1, register the low WIDTH bits as result and go to DONE.
- DONE: out_valid=1. result and flags are stable until out_ready=1, then return to IDLE.
- Arithmetic: ADD and SUB are modulo 2^WIDTH. NOTB = ~b. PASSA = a.
- Flags are computed together from the final result; they are not mutually exclusive.
  - z = (result == 0).
  - n = result[WIDTH-1].
  - v for ADD: a, b same sign and result sign differs from a.
  - v for SUB: a, b differ in sign and result sign differs from a.
  - v for MUL: upper WIDTH bits of the product nonzero (unsigned overflow).
  - v for logic ops and PASSA: 0.
- flush has priority over all other inputs in every state: next state IDLE, out_valid=0, counter cleared. A flush coincident with an accept discards the accept.
- Inputs a, b and op are don't-care outside the accepting cycle.

## Timing
- Reset values:
  - state IDLE, in_ready=1, out_valid=0, busy=0.
  - result=0, z=0, n=0, v=0, counter=0.
- Reset is asynchronous and immediate, including mid-MUL or while holding a result in DONE.
- Latency is measured from the accept edge E0:
  - non-MUL: out_valid high after E0 (1 cycle).
  - MUL: out_valid high after edge E0+WIDTH (WIDTH cycles), busy high from after E0 until that edge.
- Throughput: no overlap.
  - in_ready falls after the accept edge.
  - in_ready rises the cycle after the out_valid & out_ready edge.
  - Peak rate is one op every 2 cycles (non-MUL).
- Backpressure: out_valid, result and flags hold unchanged for any number of cycles while out_ready=0.
- out_ready while out_valid=0 is ignored.

## Test plan
- ADD a=16'h7FFF, b=16'h0001 -> result 16'h8000, n=1, v=1, z=0; out_valid one cycle after accept.
- SUB a=16'h0005, b=16'h0005 -> result 0, z=1, n=0, v=0. SUB a=16'h8000, b=16'h0001 -> 16'h7FFF, v=1.
- MUL a=16'h0012, b=16'h0034 -> result 16'h03A8, v=0; busy for 16 cycles, out_valid exactly 16 edges after accept. MUL a=16'h0100, b=16'h0100 -> result 0, z=1, v=1.
- Backpressure: XOR a=16'hF0F0, b=16'hFF00 with out_ready=0 for 10 cycles -> result 16'h0F F0 (16'h0FF0), n=0, stable throughout; in_ready=0 throughout; in_ready=1 the cycle after out_ready pulses.
- Abort: pulse flush at cycle 5 of MUL -> IDLE next cycle, out_valid never asserted. Then assert reset_n=0 mid-MUL with no clock edge -> all outputs at reset values immediately.
- Parameter sweep WIDTH=8: ADD 8'h7F+8'h01 -> 8'h80, v=1; MUL 8'h0F*8'h11 -> 8'hFF, v=0, latency 8 cycles.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops and a WIDTH-cycle shift-add MUL.
// The result and the Z/N/V flags are registered and held in DONE until the consumer accepts them.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             z,
   output logic             n,
   output logic             v,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_NOTB  = 3'b011;
   localparam logic [2:0] OP_OR    = 3'b100;
   localparam logic [2:0] OP_XOR   = 3'b101;
   localparam logic [2:0] OP_MUL   = 3'b110;
   localparam logic [2:0] OP_PASSA = 3'b111;

   localparam int MSB = WIDTH - 1;

   state_t             r_state;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic               r_z;
   logic               r_n;
   logic               r_v;

   logic [WIDTH-1:0]   w_alu_res;
   logic               w_alu_v;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0]   w_mul_res;

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      w_alu_res = '0;
      w_alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            w_alu_res = a + b;
            w_alu_v   = (a[MSB] == b[MSB]) && (w_alu_res[MSB] != a[MSB]);
         end
         OP_SUB: begin
            w_alu_res = a - b;
            w_alu_v   = (a[MSB] != b[MSB]) && (w_alu_res[MSB] != a[MSB]);
         end
         OP_AND:   w_alu_res = a & b;
         OP_NOTB:  w_alu_res = ~b;
         OP_OR:    w_alu_res = a | b;
         OP_XOR:   w_alu_res = a ^ b;
         OP_PASSA: w_alu_res = a;
         default:  w_alu_res = '0;
      endcase
   end

   // One multiplier bit per clock: add the shifted multiplicand when the current bit is set.
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mul_res  = w_acc_next[WIDTH-1:0];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_z      <= 1'b0;
         r_n      <= 1'b0;
         r_v      <= 1'b0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (op == OP_MUL) begin
                     r_mcand  <= {{WIDTH{1'b0}}, a};
                     r_mplier <= b;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                     r_state  <= S_MUL;
                  end else begin
                     r_result <= w_alu_res;
                     r_z      <= (w_alu_res == '0);
                     r_n      <= w_alu_res[MSB];
                     r_v      <= w_alu_v;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_result <= w_mul_res;
                  r_z      <= (w_mul_res == '0);
                  r_n      <= w_mul_res[MSB];
                  r_v      <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_cnt    <= '0;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_MUL);
   assign result    = r_result;
   assign z         = r_z;
   assign n         = r_n;
   assign v         = r_v;

endmodule
